// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared encodings and types for the MEM-stage load/store unit
package mem_stage_lsu_pkg;

  // Load/store width and sign selection carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Write-back source select
  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;
  localparam logic [1:0] RS_UJ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // Contents of the MEM/WB pipeline register
  typedef struct packed {
    logic        regWrt;
    logic [1:0]  rsltSrc;
    logic [31:0] aluRslt;
    logic [31:0] rdData;
    logic [31:0] pc4;
    logic [31:0] ujWrtBck;
    logic [4:0]  rd;
    logic        excMisal;
    logic        excBus;
  } mem_wb_t;

  // An instruction touches data memory if it stores or writes back a load result
  function automatic logic is_mem_op(input logic memWrt, input logic [1:0] rsltSrc);
    return memWrt | (rsltSrc == RS_MEM);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - req/gnt/rvalid data-memory bus
interface mem_stage_lsu_if;
  logic        dmReq;
  logic        dmWe;
  logic [31:0] dmAddr;
  logic [3:0]  dmBe;
  logic [31:0] dmWData;
  logic        dmGnt;
  logic        dmRValid;
  logic [31:0] dmRData;

  modport master (
    output dmReq, dmWe, dmAddr, dmBe, dmWData,
    input  dmGnt, dmRValid, dmRData
  );

  modport slave (
    input  dmReq, dmWe, dmAddr, dmBe, dmWData,
    output dmGnt, dmRValid, dmRData
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// rtl/mem_stage_lsu_align.sv - byte enables, store lane replication, access checks, load extension
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_store_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misal_o,
  output logic        illegal_o,
  output logic [31:0] ld_ext_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte and halfword out of the returned word
  always_comb begin
    byte_lane = ld_data_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_lane = ld_data_i[7:0];
      2'd1:    byte_lane = ld_data_i[15:8];
      2'd2:    byte_lane = ld_data_i[23:16];
      default: byte_lane = ld_data_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
  end

  // Byte enables, replicated store data and access legality by width
  always_comb begin
    be_o      = 4'b0000;
    wdata_o   = st_data_i;
    misal_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{st_data_i[7:0]}};
        illegal_o = is_store_i & (funct3_i == F3_BU);
      end
      F3_H, F3_HU: begin
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{st_data_i[15:0]}};
        misal_o   = addr_lo_i[0];
        illegal_o = is_store_i & (funct3_i == F3_HU);
      end
      F3_W: begin
        be_o    = 4'b1111;
        misal_o = (addr_lo_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Sign- or zero-extend the selected lane into a full register value
  always_comb begin
    ld_ext_o = 32'h0;
    case (funct3_i)
      F3_B:    ld_ext_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   ld_ext_o = {24'h0, byte_lane};
      F3_H:    ld_ext_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   ld_ext_o = {16'h0, half_lane};
      F3_W:    ld_ext_o = ld_data_i;
      default: ld_ext_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory stage: load/store FSM, timeout and MEM/WB register
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWrtm,
  input  logic                  memWrtm,
  input  logic [1:0]            rsltSrcm,
  input  logic [2:0]            funct3m,
  input  logic [31:0]           aluRsltm,
  input  logic [31:0]           wrtDm,
  input  logic [31:0]           pc4m,
  input  logic [31:0]           ujWrtBckm,
  input  logic [4:0]            rdm,
  output logic                  stallM,
  mem_stage_lsu_if.master       dm,
  output logic                  regWrtw,
  output logic [1:0]            rsltSrcw,
  output logic [31:0]           aluRsltw,
  output logic [31:0]           rdDataw,
  output logic [31:0]           pc4w,
  output logic [31:0]           ujWrtBckw,
  output logic [4:0]            rdw,
  output logic                  excMisalw,
  output logic                  excBusw
);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_wb_t          wb_q, wb_d;

  logic        mem_op, fault, issue, at_limit;
  logic        req, stall, done, abort;
  logic [3:0]  be;
  logic [31:0] wdata, ld_ext;
  logic        misal, illegal;

  mem_stage_lsu_align u_align (
    .funct3_i   (funct3m),
    .addr_lo_i  (aluRsltm[1:0]),
    .is_store_i (memWrtm),
    .st_data_i  (wrtDm),
    .ld_data_i  (dm.dmRData),
    .be_o       (be),
    .wdata_o    (wdata),
    .misal_o    (misal),
    .illegal_o  (illegal),
    .ld_ext_o   (ld_ext)
  );

  assign mem_op   = is_mem_op(memWrtm, rsltSrcm);
  assign fault    = mem_op & (misal | illegal);
  assign issue    = mem_op & ~(misal | illegal);
  // The last permitted cycle in REQ/WAIT is the one where the count reaches TIMEOUT_CYCLES-1
  assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: issue from IDLE, wait for grant in REQ, wait for data in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (issue && !done) state_d = dm.dmGnt ? WAIT : REQ;
      REQ: begin
        if (abort)         state_d = IDLE;
        else if (dm.dmGnt) state_d = memWrtm ? IDLE : WAIT;
      end
      WAIT: if (done || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request, completion, timeout abort and pipeline stall
  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    done  = 1'b0;
    abort = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: if (issue) begin
          req   = 1'b1;
          done  = dm.dmGnt & (memWrtm | dm.dmRValid);
          stall = ~done;
        end
        REQ: begin
          if (at_limit) abort = 1'b1;
          else begin
            req   = 1'b1;
            done  = dm.dmGnt & memWrtm;
            stall = ~done;
          end
        end
        WAIT: begin
          if (dm.dmRValid)   done  = 1'b1;
          else if (at_limit) abort = 1'b1;
          else               stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Timeout counter next-state: zero in and on entry to IDLE, saturating count otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || state_d == IDLE)  cnt_d = '0;
    else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // MEM/WB next-state: bubble while stalled, bus-error bubble on abort, full capture otherwise
  always_comb begin
    wb_d = wb_q;
    if (abort) begin
      wb_d.regWrt   = 1'b0;
      wb_d.excMisal = 1'b0;
      wb_d.excBus   = 1'b1;
    end else if (stall) begin
      wb_d.regWrt   = 1'b0;
      wb_d.excMisal = 1'b0;
      wb_d.excBus   = 1'b0;
    end else begin
      wb_d.regWrt   = regWrtm & ~fault;
      wb_d.rsltSrc  = rsltSrcm;
      wb_d.aluRslt  = aluRsltm;
      wb_d.rdData   = (issue && !memWrtm) ? ld_ext : 32'h0;
      wb_d.pc4      = pc4m;
      wb_d.ujWrtBck = ujWrtBckm;
      wb_d.rd       = rdm;
      wb_d.excMisal = fault;
      wb_d.excBus   = 1'b0;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  // The bus is driven only while a request is presented so idle cycles stay quiet
  assign stallM     = stall;
  assign dm.dmReq   = req;
  assign dm.dmWe    = req & memWrtm;
  assign dm.dmAddr  = req ? {aluRsltm[31:2], 2'b00} : 32'h0;
  assign dm.dmBe    = req ? be : 4'b0000;
  assign dm.dmWData = req ? wdata : 32'h0;

  assign regWrtw   = wb_q.regWrt;
  assign rsltSrcw  = wb_q.rsltSrc;
  assign aluRsltw  = wb_q.aluRslt;
  assign rdDataw   = wb_q.rdData;
  assign pc4w      = wb_q.pc4;
  assign ujWrtBckw = wb_q.ujWrtBck;
  assign rdw       = wb_q.rd;
  assign excMisalw = wb_q.excMisal;
  assign excBusw   = wb_q.excBus;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for the MEM-stage load/store unit
module tb_mem_stage_lsu;

  localparam int TO = 255;

  logic        clk;
  logic        rst;
  logic        regWrtm, memWrtm;
  logic [1:0]  rsltSrcm;
  logic [2:0]  funct3m;
  logic [31:0] aluRsltm, wrtDm, pc4m, ujWrtBckm;
  logic [4:0]  rdm;
  logic        stallM;
  logic        regWrtw;
  logic [1:0]  rsltSrcw;
  logic [31:0] aluRsltw, rdDataw, pc4w, ujWrtBckw;
  logic [4:0]  rdw;
  logic        excMisalw, excBusw;

  int total = 0;
  int bad   = 0;
  logic [3:0]  obs_be;
  logic [31:0] obs_wd;

  mem_stage_lsu_if dm_if ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .regWrtm(regWrtm), .memWrtm(memWrtm), .rsltSrcm(rsltSrcm), .funct3m(funct3m),
    .aluRsltm(aluRsltm), .wrtDm(wrtDm), .pc4m(pc4m), .ujWrtBckm(ujWrtBckm), .rdm(rdm),
    .stallM(stallM), .dm(dm_if),
    .regWrtw(regWrtw), .rsltSrcw(rsltSrcw), .aluRsltw(aluRsltw), .rdDataw(rdDataw),
    .pc4w(pc4w), .ujWrtBckw(ujWrtBckw), .rdw(rdw),
    .excMisalw(excMisalw), .excBusw(excBusw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic ref_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = ref_size(f3);
    if (sz == 0) return 1'b1;
    if (st && f3[2]) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = ref_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (ref_size(f3))
      1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz   = ref_size(f3);
    v    = rd >> (8 * (a % 4));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v    = v & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive_bubble();
    regWrtm = 0; memWrtm = 0; rsltSrcm = 0; funct3m = 0;
    aluRsltm = 0; wrtDm = 0; pc4m = 0; ujWrtBckm = 0; rdm = 0;
  endtask

  // kind: 0 ALU, 1 load, 2 store; gd = grant delay, rv = extra cycles from grant to rvalid
  task automatic run_op(input int kind, input logic [1:0] alu_rs, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input logic [4:0] rd, input int gd, input int rv);
    logic is_ld, is_st, mem, flt, exp_req;
    logic [31:0] p4, uj;
    int done_c;
    is_ld = (kind == 1);
    is_st = (kind == 2);
    mem   = is_ld | is_st;
    flt   = mem && ref_fault(is_st, f3, addr);
    if (!mem || flt) gd = 0;
    if (gd > 0 && rv == 0) rv = 1;
    done_c = (!mem || flt) ? 0 : (is_st ? gd : gd + rv);
    p4 = $urandom;
    uj = $urandom;
    regWrtm   = !is_st;
    memWrtm   = is_st;
    rsltSrcm  = is_ld ? 2'b01 : (is_st ? 2'b00 : alu_rs);
    funct3m   = f3;
    aluRsltm  = addr;
    wrtDm     = wd;
    pc4m      = p4;
    ujWrtBckm = uj;
    rdm       = rd;
    for (int c = 0; c <= done_c; c++) begin
      if (!mem || flt) begin
        dm_if.dmGnt    = 1'($urandom_range(0, 1));
        dm_if.dmRValid = 1'($urandom_range(0, 1));
      end else begin
        dm_if.dmGnt    = (c == gd) ? 1'b1 : ((c > gd) ? 1'($urandom_range(0, 1)) : 1'b0);
        dm_if.dmRValid = (is_ld && c == gd + rv) ? 1'b1 : ((c < gd) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      dm_if.dmRData = (c == gd + rv) ? rdata : $urandom;
      @(negedge clk);
      exp_req = mem && !flt && (c <= gd);
      chk("stallM", stallM, c != done_c);
      chk("dmReq", dm_if.dmReq, exp_req);
      if (exp_req) begin
        obs_be = dm_if.dmBe;
        obs_wd = dm_if.dmWData;
        chk("dmWe", dm_if.dmWe, is_st);
        chk("dmAddr", dm_if.dmAddr, {addr[31:2], 2'b00});
        chk("dmBe", dm_if.dmBe, ref_be(f3, addr));
        if (is_st) chk("dmWData", dm_if.dmWData, ref_wdata(f3, wd));
      end
      @(posedge clk);
      #1;
      if (c != done_c) begin
        chk("bubble_regWrtw", regWrtw, 0);
        chk("bubble_exc", {excMisalw, excBusw}, 0);
      end
    end
    dm_if.dmGnt    = 0;
    dm_if.dmRValid = 0;
    chk("wb_regWrtw", regWrtw, flt ? 1'b0 : !is_st);
    chk("wb_excMisalw", excMisalw, flt);
    chk("wb_excBusw", excBusw, 0);
    chk("wb_rsltSrcw", rsltSrcw, is_ld ? 2'b01 : (is_st ? 2'b00 : alu_rs));
    chk("wb_aluRsltw", aluRsltw, addr);
    chk("wb_rdw", rdw, rd);
    chk("wb_pc4w", pc4w, p4);
    chk("wb_ujWrtBckw", ujWrtBckw, uj);
    chk("wb_rdDataw", rdDataw, (is_ld && !flt) ? ref_load(f3, addr, rdata) : 32'h0);
  endtask

  initial begin
    logic [2:0] legal_ld [5];
    logic [2:0] legal_st [3];
    int kind;
    logic [2:0] f3;
    logic [1:0] ars;
    legal_ld[0] = 3'b000; legal_ld[1] = 3'b001; legal_ld[2] = 3'b010;
    legal_ld[3] = 3'b100; legal_ld[4] = 3'b101;
    legal_st[0] = 3'b000; legal_st[1] = 3'b001; legal_st[2] = 3'b010;

    rst = 1;
    drive_bubble();
    dm_if.dmGnt = 0; dm_if.dmRValid = 0; dm_if.dmRData = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_regWrtw", regWrtw, 0);
    chk("reset_aluRsltw", aluRsltw, 0);
    chk("reset_rdDataw", rdDataw, 0);
    chk("reset_exc", {excMisalw, excBusw}, 0);
    chk("reset_stall_req", {stallM, dm_if.dmReq}, 0);
    rst = 0;

    // 1: plain ALU op
    run_op(0, 2'b00, 3'b000, 32'h0000_1234, 0, 0, 5'd5, 0, 0);
    chk("t1_aluRsltw", aluRsltw, 32'h0000_1234);
    // 2: SB to the top lane, zero-wait grant
    run_op(2, 2'b00, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 5'd0, 0, 0);
    chk("t2_be", obs_be, 4'b1000);
    chk("t2_wdata", obs_wd, 32'hABAB_ABAB);
    // 3: LB with rvalid three cycles after grant
    run_op(1, 2'b00, 3'b000, 32'h0000_2001, 0, 32'h0000_8000, 5'd7, 0, 3);
    chk("t3_rdDataw", rdDataw, 32'hFFFF_FF80);
    // 4: LHU zero-wait
    run_op(1, 2'b00, 3'b101, 32'h0000_2002, 0, 32'h8001_0000, 5'd8, 0, 0);
    chk("t4_rdDataw", rdDataw, 32'h0000_8001);
    // 5: misaligned LW
    run_op(1, 2'b00, 3'b010, 32'h0000_3002, 0, 0, 5'd9, 0, 0);
    chk("t5_excMisalw", excMisalw, 1);

    // 6: grant withheld until the timeout abort, then a stray rvalid
    regWrtm = 1; memWrtm = 0; rsltSrcm = 2'b01; funct3m = 3'b010;
    aluRsltm = 32'h0000_4000; rdm = 5'd10;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      chk("t6_stall", stallM, 1);
      chk("t6_req", dm_if.dmReq, 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t6_abort_stall", stallM, 0);
    chk("t6_abort_req", dm_if.dmReq, 0);
    @(posedge clk);
    #1;
    chk("t6_excBusw", excBusw, 1);
    chk("t6_regWrtw", regWrtw, 0);
    drive_bubble();
    dm_if.dmRValid = 1;
    dm_if.dmRData  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t6_stray_stall", stallM, 0);
    @(posedge clk);
    #1;
    dm_if.dmRValid = 0;
    chk("t6_excBus_once", excBusw, 0);
    chk("t6_stray_rdDataw", rdDataw, 0);

    // 7: reset while waiting for load data
    regWrtm = 1; memWrtm = 0; rsltSrcm = 2'b01; funct3m = 3'b010;
    aluRsltm = 32'h0000_5000; rdm = 5'd11;
    dm_if.dmGnt = 1;
    @(negedge clk);
    chk("t7_stall", stallM, 1);
    @(posedge clk);
    #1;
    dm_if.dmGnt = 0;
    rst = 1;
    drive_bubble();
    @(negedge clk);
    chk("t7_rst_stall_req", {stallM, dm_if.dmReq}, 0);
    @(posedge clk);
    #1;
    chk("t7_rst_wb", {regWrtw, excMisalw, excBusw, rdw}, 0);
    chk("t7_rst_data", rdDataw | aluRsltw | pc4w | ujWrtBckw, 0);
    rst = 0;
    dm_if.dmRValid = 1;
    dm_if.dmRData  = 32'h1234_5678;
    @(negedge clk);
    chk("t7_late_stall_req", {stallM, dm_if.dmReq}, 0);
    @(posedge clk);
    #1;
    dm_if.dmRValid = 0;
    chk("t7_late_wb", {regWrtw, excBusw}, 0);
    run_op(1, 2'b00, 3'b000, 32'h0000_6003, 0, 32'h7F00_0000, 5'd12, 0, 0);

    // Randomized mix of ALU ops, loads and stores with random bus timing
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (kind == 2)            f3 = legal_st[$urandom_range(0, 2)];
      else                           f3 = legal_ld[$urandom_range(0, 4)];
      case ($urandom_range(0, 2))
        0:       ars = 2'b00;
        1:       ars = 2'b10;
        default: ars = 2'b11;
      endcase
      run_op(kind, ars, f3, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
